itoa: RTL and testbench

- Integer-to-ASCII converter. The write-side counterpart of the string-to-integer parser.
- Takes a DSZ-bit value and writes its decimal (signed) or hex (unsigned) text into byte memory, one byte per cycle. The text is most-significant digit first.
- Sits beside the number parser in the Forth core. It serves the number-output words ("." and "U." style) and builds strings that the parser can read back unchanged.

---
 rtl/itoa_pkg.sv | 18 +
 rtl/itoa_if.sv | 20 ++
 rtl/itoa_div.sv | 55 +++++
 rtl/itoa.sv | 134 +++++++++++++
 tb/tb_itoa.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/itoa_pkg.sv
// Shared Forth-core types and constants for the integer-to-ASCII converter.
// No logic; state encoding, ASCII constants and digit-stack depth only.
package forthsuper_pkg;

  typedef enum logic [2:0] {IT0, SGN, CNV, EMT, TRM} itoa_sts;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h61;
  localparam logic [7:0] ASC_MINUS = 8'h2d;

  // decimal digit count of 2^32
  localparam int DEPTH = 10;

  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d < 4'd10) ? ASC_0 + {4'd0, d} : ASC_A + {4'd0, d} - 8'd10;
  endfunction

endpackage

// File: rtl/itoa_if.sv
// Start/result and byte-write bundle between a requester and itoa.
// Requester drives en/hex/vi/ai; itoa drives the write strobe and status.
interface itoa_if #(
  parameter int DSZ = 32,
  parameter int ASZ = 17
);
  logic           en;
  logic           hex;
  logic [DSZ-1:0] vi;
  logic [ASZ-1:0] ai;
  logic           we;
  logic [ASZ-1:0] ao;
  logic [7:0]     vo;
  logic           bsy;
  logic [4:0]     len;
  logic [2:0]     st;

  modport master (output en, hex, vi, ai, input we, ao, vo, bsy, len, st);
  modport slave  (input en, hex, vi, ai, output we, ao, vo, bsy, len, st);
endinterface

// File: rtl/itoa_div.sv
// Sequential restoring divide of a DSZ-bit unsigned value by 10.
// Latency: start cycle performs the first step, done after DSZ cycles; start restarts at any time.
module itoa_div #(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DSZ-1:0] n,
  output logic [DSZ-1:0] q,
  output logic [3:0]     r,
  output logic           done
);
  localparam int CW = $clog2(DSZ + 1);

  logic [DSZ-1:0] a, a_nx, src;
  logic [3:0]     rem, rem_nx;
  logic [4:0]     part, diff;
  logic [CW-1:0]  cnt;
  logic           act, ge;

  // a shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    src    = start ? n : a;
    part   = {(start ? 4'd0 : rem), src[DSZ-1]};
    diff   = part - 5'd10;
    ge     = ~diff[4];
    a_nx   = {src[DSZ-2:0], ge};
    rem_nx = ge ? diff[3:0] : part[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      rem <= '0;
      cnt <= '0;
      act <= 1'b0;
    end else if (start) begin
      a   <= a_nx;
      rem <= rem_nx;
      cnt <= CW'(DSZ - 1);
      act <= 1'b1;
    end else if (act && cnt != '0) begin
      a   <= a_nx;
      rem <= rem_nx;
      cnt <= cnt - CW'(1);
    end else if (act) begin
      act <= 1'b0;
    end
  end

  assign q    = a;
  assign r    = rem;
  assign done = act && (cnt == '0);
endmodule

// File: rtl/itoa.sv
// Integer to ASCII (signed decimal / unsigned hex), one byte per cycle MSD first; no backpressure, en ignored while bsy.
// Latency hex 1+2*digits, decimal 1+neg+digits*(DSZ+2); FORTHSUPER_ITOA_NUL_EN adds a NUL write in TRM.
module itoa #(
  parameter int DSZ = 32,
  parameter int ASZ = 17
) (
  input logic   clk,
  input logic   rst,
  itoa_if.slave io
);
  import forthsuper_pkg::*;

  itoa_sts        st_r;
  logic           we_r, bsy_r, hexr, dgo;
  logic [ASZ-1:0] ao_r, nxt;
  logic [7:0]     vo_r;
  logic [4:0]     len_r;
  logic [DSZ-1:0] mag, dq;
  logic [3:0]     dr, dig;
  logic [3:0]     stk [DEPTH];
  logic [3:0]     sp;
  logic           ddone, dstart, dv, last, push;

  itoa_div #(.DSZ(DSZ)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (dstart),
    .n     (mag),
    .q     (dq),
    .r     (dr),
    .done  (ddone)
  );

  always_comb begin
    dstart = (st_r == CNV) && !hexr && !dgo;
    dv     = hexr || (dgo && ddone);
    dig    = hexr ? mag[3:0] : dr;
    last   = hexr ? (mag[DSZ-1:4] == '0) : (dq == '0);
    push   = (st_r == CNV) && dv && !last;
  end

  // the most significant digit is emitted directly instead of pushed
  always_ff @(posedge clk) begin
    if (push) stk[sp] <= dig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_r  <= IT0;
      we_r  <= 1'b0;
      bsy_r <= 1'b0;
      ao_r  <= '0;
      vo_r  <= '0;
      len_r <= '0;
      sp    <= '0;
      dgo   <= 1'b0;
      hexr  <= 1'b0;
      mag   <= '0;
      nxt   <= '0;
    end else begin
      we_r <= 1'b0;
      case (st_r)
        IT0: if (io.en) begin
          hexr  <= io.hex;
          bsy_r <= 1'b1;
          len_r <= '0;
          sp    <= '0;
          dgo   <= 1'b0;
          if (!io.hex && io.vi[DSZ-1]) begin
            mag   <= -io.vi;
            we_r  <= 1'b1;
            vo_r  <= ASC_MINUS;
            ao_r  <= io.ai;
            nxt   <= io.ai + ASZ'(1);
            len_r <= 5'd1;
            st_r  <= SGN;
          end else begin
            mag  <= io.vi;
            nxt  <= io.ai;
            st_r <= CNV;
          end
        end
        SGN: st_r <= CNV;
        CNV: begin
          if (dstart) begin
            dgo <= 1'b1;
          end else if (dv) begin
            dgo <= 1'b0;
            if (last) begin
              we_r  <= 1'b1;
              vo_r  <= asc(dig);
              ao_r  <= nxt;
              nxt   <= nxt + ASZ'(1);
              len_r <= len_r + 5'd1;
              st_r  <= EMT;
            end else begin
              sp  <= sp + 4'd1;
              mag <= hexr ? (mag >> 4) : dq;
            end
          end
        end
        EMT: begin
          if (sp != '0) begin
            we_r  <= 1'b1;
            vo_r  <= asc(stk[sp - 4'd1]);
            ao_r  <= nxt;
            nxt   <= nxt + ASZ'(1);
            len_r <= len_r + 5'd1;
            sp    <= sp - 4'd1;
          end else begin
`ifdef FORTHSUPER_ITOA_NUL_EN
            we_r <= 1'b1;
            vo_r <= 8'h00;
            ao_r <= nxt;
`endif
            st_r <= TRM;
          end
        end
        TRM: begin
          bsy_r <= 1'b0;
          st_r  <= IT0;
        end
        default: st_r <= IT0;
      endcase
    end
  end

  assign io.we  = we_r;
  assign io.ao  = ao_r;
  assign io.vo  = vo_r;
  assign io.bsy = bsy_r;
  assign io.len = len_r;
  assign io.st  = st_r;
endmodule

// File: tb/tb_itoa.sv
// Directed and random conversions checked byte-by-byte against hand/format-derived strings.
// Also covers reset priority, mid-write abort, address wrap and en while busy.
module tb_itoa;
`ifdef FORTHSUPER_ITOA_NUL_EN
  localparam int NUL = 1;
`else
  localparam int NUL = 0;
`endif
  localparam int MAXC = 2000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   wcnt = 0;
  logic [7:0] mem [int];

  always #5 clk = ~clk;

  itoa_if #(.DSZ(32), .ASZ(17)) b();
  itoa dut (.clk(clk), .rst(rst), .io(b));

  always @(posedge clk) begin
    if (b.we) begin
      mem[int'(b.ao)] = b.vo;
      wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic conv(input string nm, input logic [31:0] v, input logic h,
                      input logic [16:0] a, input string s, input bit poke);
    int n;
    int k;
    logic [16:0] ad;
    logic [7:0]  g;
    mem.delete();
    wcnt = 0;
    @(negedge clk);
    b.en = 1'b1; b.hex = h; b.vi = v; b.ai = a;
    @(negedge clk);
    b.en = 1'b0; b.vi = ~v; b.hex = ~h; b.ai = a + 17'h40;
    chk({nm, ".bsy"}, 64'(b.bsy), 64'd1);
    if (poke) begin
      repeat (3) @(negedge clk);
      b.en = 1'b1; b.vi = 32'h5; b.hex = ~h;
      @(negedge clk);
      b.en = 1'b0;
    end
    n = 0;
    while (b.bsy && n < MAXC) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".done"}, 64'(n < MAXC), 64'd1);
    chk({nm, ".len"}, 64'(b.len), 64'(s.len()));
    chk({nm, ".wcnt"}, 64'(wcnt), 64'(s.len() + NUL));
    for (int i = 0; i < s.len(); i++) begin
      ad = a + 17'(i);
      k  = int'(ad);
      g  = mem.exists(k) ? mem[k] : 8'hxx;
      chk($sformatf("%s.byte%0d", nm, i), 64'(g), 64'(s[i]));
    end
`ifdef FORTHSUPER_ITOA_NUL_EN
    ad = a + 17'(s.len());
    k  = int'(ad);
    g  = mem.exists(k) ? mem[k] : 8'hxx;
    chk({nm, ".nul"}, 64'(g), 64'd0);
`endif
    ad = a + 17'(s.len() - 1 + NUL);
    chk({nm, ".ao"}, 64'(b.ao), 64'(ad));
    chk({nm, ".st"}, 64'(b.st), 64'd0);
    k = wcnt;
    repeat (3) @(negedge clk);
    chk({nm, ".idle"}, 64'(wcnt), 64'(k));
  endtask

  initial begin
    int n;
    int k;
    logic [31:0] v;
    rst = 1'b1;
    b.en = 1'b1; b.hex = 1'b0; b.vi = 32'd5; b.ai = 17'h10;
    repeat (3) @(negedge clk);
    chk("rst.bsy", 64'(b.bsy), 64'd0);
    chk("rst.we",  64'(b.we),  64'd0);
    chk("rst.ao",  64'(b.ao),  64'd0);
    chk("rst.vo",  64'(b.vo),  64'd0);
    chk("rst.len", 64'(b.len), 64'd0);
    chk("rst.st",  64'(b.st),  64'd0);
    b.en = 1'b0;
    rst  = 1'b0;

    conv("d12345", 32'd12345,      1'b0, 17'h100, "12345", 1'b0);
    conv("dm7",    32'hFFFFFFF9,   1'b0, 17'h100, "-7", 1'b0);
    conv("dmin",   32'h80000000,   1'b0, 17'h100, "-2147483648", 1'b0);
    conv("dmax",   32'h7FFFFFFF,   1'b0, 17'h100, "2147483647", 1'b0);
    conv("dzero",  32'd0,          1'b0, 17'h100, "0", 1'b0);
    conv("dm1wrp", 32'hFFFFFFFF,   1'b0, 17'h1FFFF, "-1", 1'b0);
    conv("hdead",  32'hDEADBEEF,   1'b1, 17'h100, "deadbeef", 1'b1);
    conv("hff",    32'hFFFFFFFF,   1'b1, 17'h100, "ffffffff", 1'b0);
    conv("hzero",  32'd0,          1'b1, 17'h100, "0", 1'b0);
    conv("hwrap",  32'h123,        1'b1, 17'h1FFFE, "123", 1'b0);
    conv("dpoke",  32'd907,        1'b0, 17'h300, "907", 1'b1);

    // abort during the emit phase
    mem.delete();
    wcnt = 0;
    @(negedge clk);
    b.en = 1'b1; b.hex = 1'b0; b.vi = 32'd12345; b.ai = 17'h200;
    @(negedge clk);
    b.en = 1'b0;
    n = 0;
    while (wcnt < 2 && n < MAXC) begin
      @(negedge clk);
      n++;
    end
    chk("abort.reach", 64'(n < MAXC), 64'd1);
    chk("abort.st_emt", 64'(b.st), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.we",  64'(b.we),  64'd0);
    chk("abort.bsy", 64'(b.bsy), 64'd0);
    chk("abort.st",  64'(b.st),  64'd0);
    chk("abort.len", 64'(b.len), 64'd0);
    k = wcnt;
    repeat (5) @(negedge clk);
    chk("abort.quiet", 64'(wcnt), 64'(k));

    for (int i = 0; i < 20; i++) begin
      v = $urandom;
      conv($sformatf("rh%0d", i), v, 1'b1, 17'($urandom), $sformatf("%0h", v), 1'b0);
      v = $urandom;
      conv($sformatf("rd%0d", i), v, 1'b0, 17'($urandom), $sformatf("%0d", $signed(v)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
